// File: rtl/aes_enc_axi_master.sv
// Initiator for the AES256 core's word-serial write port: streams one plaintext block as
// data beats and a control beat, then collects the 128-bit ciphertext for the host.
module aes_enc_axi_master #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned N_WORDS = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        blk_valid_i,
    output logic                        blk_ready_o,
    input  logic [DATA_W*N_WORDS-1:0]   blk_data_i,
    input  logic [DATA_W-1:0]           ctrl_word_i,
    output logic                        wr_valid_o,
    output logic                        wr_addr_o,
    output logic [DATA_W-1:0]           wr_data_o,
    input  logic                        wr_ready_i,
    input  logic                        rd_valid_i,
    input  logic [DATA_W*N_WORDS-1:0]   rd_data_i,
    output logic                        rd_ready_o,
    output logic                        res_valid_o,
    output logic [DATA_W*N_WORDS-1:0]   res_data_o,
    input  logic                        res_ready_i,
    output logic                        err_timeout_o
);

    localparam int unsigned BLK_W = DATA_W * N_WORDS;
    localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND_DATA = 3'd1;
    localparam logic [2:0] ST_SEND_CTRL = 3'd2;
    localparam logic [2:0] ST_WAIT_RES  = 3'd3;
    localparam logic [2:0] ST_HOLD_RES  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [DATA_W-1:0] ctrl_q, ctrl_d;
    logic [BLK_W-1:0]  res_q, res_d;

    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        cnt_d         = cnt_q;
        blk_d         = blk_q;
        ctrl_d        = ctrl_q;
        res_d         = res_q;
        blk_ready_o   = 1'b0;
        wr_valid_o    = 1'b0;
        wr_addr_o     = 1'b0;
        wr_data_o     = '0;
        rd_ready_o    = 1'b0;
        res_valid_o   = 1'b0;
        err_timeout_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                blk_ready_o = 1'b1;
                if (blk_valid_i) begin
                    blk_d      = blk_data_i;
                    ctrl_d     = ctrl_word_i;
                    word_idx_d = '0;
                    state_d    = ST_SEND_DATA;
                end
            end
            ST_SEND_DATA: begin
                // Block is held as a shift register so the current word is always on top.
                wr_valid_o = 1'b1;
                wr_addr_o  = 1'b1;
                wr_data_o  = blk_q[BLK_W-1 -: DATA_W];
                if (wr_ready_i) begin
                    blk_d = blk_q << DATA_W;
                    if (word_idx_q == LAST_IDX) begin
                        word_idx_d = '0;
                        state_d    = ST_SEND_CTRL;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
            end
            ST_SEND_CTRL: begin
                wr_valid_o = 1'b1;
                wr_addr_o  = 1'b0;
                wr_data_o  = ctrl_q;
                if (wr_ready_i) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                rd_ready_o = 1'b1;
                // A result arriving on the expiry cycle takes priority over the abort.
                if (rd_valid_i) begin
                    res_d   = rd_data_i;
                    state_d = ST_HOLD_RES;
                end else if (cnt_q == CNT_MAX) begin
                    err_timeout_o = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD_RES: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset forces every handshake output low, including the cycle it is first applied.
        if (reset_i) begin
            blk_ready_o   = 1'b0;
            wr_valid_o    = 1'b0;
            wr_addr_o     = 1'b0;
            wr_data_o     = '0;
            rd_ready_o    = 1'b0;
            res_valid_o   = 1'b0;
            err_timeout_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            cnt_q      <= '0;
            blk_q      <= '0;
            ctrl_q     <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            cnt_q      <= cnt_d;
            blk_q      <= blk_d;
            ctrl_q     <= ctrl_d;
            res_q      <= res_d;
        end
    end

    assign res_data_o = res_q;

endmodule

// File: tb/tb_aes_enc_axi_master.sv
// Directed and randomized bench for aes_enc_axi_master with a beat-list reference model.
module tb_aes_enc_axi_master;

    localparam int unsigned TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid, blk_ready;
    logic [127:0] blk_data;
    logic [31:0]  ctrl_word;
    logic         wr_valid, wr_addr, wr_ready;
    logic [31:0]  wr_data;
    logic         rd_valid, rd_ready;
    logic [127:0] rd_data;
    logic         res_valid, res_ready, err_timeout;
    logic [127:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] got_q[$];
    logic        stall_q = 1'b0;
    logic [32:0] stall_beat_q;

    always #5 clk = ~clk;

    aes_enc_axi_master #(
        .DATA_W  (32),
        .N_WORDS (4),
        .TIMEOUT (TO)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .blk_valid_i   (blk_valid),
        .blk_ready_o   (blk_ready),
        .blk_data_i    (blk_data),
        .ctrl_word_i   (ctrl_word),
        .wr_valid_o    (wr_valid),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .wr_ready_i    (wr_ready),
        .rd_valid_i    (rd_valid),
        .rd_data_i     (rd_data),
        .rd_ready_o    (rd_ready),
        .res_valid_o   (res_valid),
        .res_data_o    (res_data),
        .res_ready_i   (res_ready),
        .err_timeout_o (err_timeout)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: word k of the block is bits [127-32k -: 32], then the control word at addr 0.
    function automatic logic [32:0] exp_beat(input logic [127:0] blk, input logic [31:0] ctrl,
                                             input int k);
        logic [127:0] sh;
        if (k < 4) begin
            sh = blk >> (96 - 32 * k);
            return {1'b1, sh[31:0]};
        end
        return {1'b0, ctrl};
    endfunction

    // Core-side monitor: records accepted beats and checks stalled beats stay put.
    always @(negedge clk) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) chk("beat_held", {wr_valid, wr_addr, wr_data}, {1'b1, stall_beat_q});
            stall_q      <= wr_valid && !wr_ready;
            stall_beat_q <= {wr_addr, wr_data};
            if (wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // mode 0: wr_ready always 1, mode 1: toggling 0/1, otherwise random
    task automatic send_block(input logic [127:0] blk, input logic [31:0] ctrl, input int mode);
        int n;
        logic [32:0] obs;
        got_q.delete();
        blk_data  = blk;
        ctrl_word = ctrl;
        blk_valid = 1'b1;
        n = 0;
        while (!blk_ready && n < 50) begin
            step();
            n++;
        end
        chk("blk_ready_idle", blk_ready, 1);
        step();
        blk_valid = 1'b0;
        blk_data  = rand128();
        ctrl_word = $urandom();
        n = 0;
        while (got_q.size() < 5 && n < 100) begin
            case (mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = n[0];
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
            step();
            n++;
        end
        wr_ready = 1'b0;
        if (mode == 0) chk("beat_cycles_zero_wait", n, 5);
        if (mode == 1) chk("beat_cycles_toggle", n, 10);
        chk("beat_count", got_q.size(), 5);
        for (int k = 0; k < 5; k++) begin
            obs = (k < got_q.size()) ? got_q[k] : 'x;
            chk($sformatf("beat%0d", k), obs, exp_beat(blk, ctrl, k));
        end
        chk("wr_valid_after_ctrl", wr_valid, 0);
        chk("rd_ready_wait", rd_ready, 1);
    endtask

    task automatic get_result(input int d, input logic [127:0] rdata, input int res_wait);
        rd_valid = 1'b0;
        for (int i = 0; i < d; i++) begin
            chk("wait_no_err", err_timeout, 0);
            chk("wait_rd_ready", rd_ready, 1);
            step();
        end
        rd_valid = 1'b1;
        rd_data  = rdata;
        #1;
        chk("capture_no_err", err_timeout, 0);
        step();
        rd_data = ~rdata;
        #1;
        chk("res_valid_hold", res_valid, 1);
        chk("res_data_hold", res_data, rdata);
        chk("rd_ready_in_hold", rd_ready, 0);
        for (int i = 0; i < res_wait; i++) begin
            step();
            chk("res_valid_stall", res_valid, 1);
            chk("res_data_stall", res_data, rdata);
        end
        res_ready = 1'b1;
        rd_valid  = 1'b0;
        step();
        res_ready = 1'b0;
        #1;
        chk("res_valid_drop", res_valid, 0);
        chk("blk_ready_after_res", blk_ready, 1);
    endtask

    task automatic expect_timeout();
        rd_valid = 1'b0;
        for (int i = 0; i < int'(TO); i++) begin
            chk($sformatf("timeout_c%0d", i), err_timeout, (i == int'(TO) - 1));
            step();
        end
        chk("timeout_pulse_end", err_timeout, 0);
        chk("timeout_blk_ready", blk_ready, 1);
        chk("timeout_rd_ready", rd_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] b0;
        logic [127:0] ct;
        b0        = 128'h01000000_02000000_03000000_04000000;
        ct        = 128'h633aadc43c56b3d6ea93bcfe994d587a;
        reset     = 1'b1;
        blk_valid = 1'b1;
        blk_data  = b0;
        ctrl_word = 32'h1;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        res_ready = 1'b0;

        // Reset with a block on offer.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_flags", {blk_ready, wr_valid, wr_addr, rd_ready, res_valid, err_timeout}, 0);
            chk("reset_wr_data", wr_data, 0);
            chk("reset_res_data", res_data, 0);
        end
        blk_valid = 1'b0;
        reset     = 1'b0;
        #1;
        chk("blk_ready_release", blk_ready, 1);

        // Zero-wait core, then 7-cycle core latency with host backpressure.
        send_block(b0, 32'h1, 0);
        get_result(7, ct, 3);

        // Toggling wr_ready.
        send_block(b0, 32'h1, 1);
        get_result(0, rand128(), 0);

        // Timeout abort, then a result on the final cycle.
        send_block(rand128(), $urandom(), 2);
        expect_timeout();
        send_block(rand128(), $urandom(), 2);
        get_result(int'(TO) - 1, rand128(), 1);

        // Reset during the third data beat.
        blk_data  = b0;
        ctrl_word = 32'h1;
        blk_valid = 1'b1;
        wr_ready  = 1'b1;
        step();
        blk_valid = 1'b0;
        step();
        step();
        chk("third_beat", {wr_valid, wr_addr, wr_data}, {2'b11, 32'h03000000});
        reset = 1'b1;
        step();
        reset    = 1'b0;
        wr_ready = 1'b0;
        #1;
        chk("reset_mid_wr_valid", wr_valid, 0);
        chk("reset_mid_blk_ready", blk_ready, 1);
        send_block(128'hdeadbeef_01234567_89abcdef_cafef00d, 32'h5, 0);
        get_result(2, rand128(), 0);

        // Randomized blocks, backpressure and latencies.
        for (int r = 0; r < 6; r++) begin
            send_block(rand128(), $urandom(), 2);
            get_result(int'($urandom_range(0, TO - 1)), rand128(), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
